// File: rtl/ql_carry_pkg.sv
// Shared definitions for the carry-chain accumulator tile: the operation
// encoding and the default datapath width.
package ql_carry_pkg;

  typedef enum logic [1:0] {
    QL_OP_HOLD = 2'b00,
    QL_OP_LOAD = 2'b01,
    QL_OP_ADD  = 2'b10,
    QL_OP_SUB  = 2'b11
  } ql_op_e;

  localparam int QL_CARRY_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ql_xor_mux2.sv
// One bit of the fabric carry chain. The XOR produces the sum bit, and the
// MUX2 either passes the incoming carry along (propagate) or injects the
// generate term.
module ql_xor_mux2 (
  input  logic p,
  input  logic g,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = p ^ ci;
  assign co  = p ? ci : g;

endmodule

// File: rtl/ql_carry_acc.sv
// Registered carry-chain accumulator. Q feeds the chain as operand A, the
// chain result lands back in Q, so load/add/subtract accumulate at one
// operation per cycle with registered carry, overflow and valid flags.
module ql_carry_acc
  import ql_carry_pkg::*;
#(
  parameter int WIDTH = QL_CARRY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             ci_ext,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             out_valid
);

  ql_op_e           op_dec;
  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             co_next;
  logic             ovf_next;
  logic             accept;

  assign op_dec = ql_op_e'(op);
  assign is_sub = (op_dec == QL_OP_SUB);
  assign accept = in_valid && (op_dec != QL_OP_HOLD);

  // Subtraction is A + ~B + 1, so invert the operand and force the carry-in.
  always_comb begin
    b_opnd   = is_sub ? ~din : din;
    carry[0] = is_sub ? 1'b1 : ci_ext;
    prop     = q ^ b_opnd;
    gen      = q & b_opnd;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    ql_xor_mux2 u_cell (
      .p   (prop[i]),
      .g   (gen[i]),
      .ci  (carry[i]),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end

  assign co_next  = carry[WIDTH];
  assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];

  // Accumulator and flag registers; clear outranks any operation in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      co         <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
    end else if (clr) begin
      q          <= '0;
      co         <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (op_dec == QL_OP_LOAD) begin
        q          <= din;
        co         <= 1'b0;
        ovf        <= 1'b0;
        ovf_sticky <= 1'b0;
      end else begin
        q          <= sum;
        co         <= co_next;
        ovf        <= ovf_next;
        ovf_sticky <= ovf_sticky | ovf_next;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ql_carry_acc.sv
// Randomised self-checking bench for ql_carry_acc at WIDTH=8. A behavioural
// model computes results with plain integer arithmetic and signed-range rules.
module tb_ql_carry_acc;
  import ql_carry_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         inValid;
  logic [1:0]   op;
  logic [W-1:0] din;
  logic         ciExt;
  logic [W-1:0] q;
  logic         co;
  logic         ovf;
  logic         ovfSticky;
  logic         outValid;

  int compareCount;
  int mismatchCount;

  logic [W-1:0] mQ;
  logic         mCo;
  logic         mOvf;
  logic         mSticky;
  logic         mValid;

  ql_carry_acc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (inValid),
    .op         (op),
    .din        (din),
    .ci_ext     (ciExt),
    .q          (q),
    .co         (co),
    .ovf        (ovf),
    .ovf_sticky (ovfSticky),
    .out_valid  (outValid)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".q"},         32'(q),         32'(mQ));
    checkOutput({tag, ".co"},        32'(co),        32'(mCo));
    checkOutput({tag, ".ovf"},       32'(ovf),       32'(mOvf));
    checkOutput({tag, ".sticky"},    32'(ovfSticky), 32'(mSticky));
    checkOutput({tag, ".out_valid"}, 32'(outValid),  32'(mValid));
  endtask

  task automatic modelReset();
    mQ = '0; mCo = 1'b0; mOvf = 1'b0; mSticky = 1'b0; mValid = 1'b0;
  endtask

  // Reference behaviour: integer add of A, B and carry-in; overflow from sign rules.
  task automatic modelStep(input logic c, input logic v, input logic [1:0] o,
                           input logic [W-1:0] d, input logic ci);
    int unsigned a, b, total;
    logic [W-1:0] res;
    logic sa, sb;
    if (c) begin
      modelReset();
    end else if (v && o != QL_OP_HOLD) begin
      mValid = 1'b1;
      if (o == QL_OP_LOAD) begin
        mQ = d; mCo = 1'b0; mOvf = 1'b0; mSticky = 1'b0;
      end else begin
        a  = int'(mQ);
        sa = mQ[W-1];
        sb = d[W-1];
        if (o == QL_OP_ADD) begin
          b     = int'(d);
          total = a + b + int'(ci);
          res   = W'(total);
          mOvf  = (sa == sb) && (res[W-1] != sa);
        end else begin
          b     = (1 << W) - 1 - int'(d);
          total = a + b + 1;
          res   = W'(total);
          mOvf  = (sa != sb) && (res[W-1] != sa);
        end
        mCo     = (total >> W) != 0;
        mQ      = res;
        mSticky = mSticky | mOvf;
      end
    end else begin
      mValid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the rising edge.
  task automatic applyStimulus(input string tag, input logic c, input logic v,
                               input logic [1:0] o, input logic [W-1:0] d,
                               input logic ci);
    @(negedge clk);
    clr = c; inValid = v; op = o; din = d; ciExt = ci;
    @(posedge clk);
    modelStep(c, v, o, d, ci);
    #1;
    checkAll(tag);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0; clr = 1'b0; inValid = 1'b0; op = QL_OP_HOLD; din = '0; ciExt = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD 0x7F then ADD 0x01: signed overflow into 0x80.
    applyStimulus("ld7f", 1'b0, 1'b1, QL_OP_LOAD, 8'h7F, 1'b0);
    checkOutput("ld7f_valid", 32'(outValid), 32'd1);
    applyStimulus("add01", 1'b0, 1'b1, QL_OP_ADD, 8'h01, 1'b0);
    checkOutput("add01_q", 32'(q), 32'h80);
    checkOutput("add01_ovf", 32'(ovf), 32'd1);
    checkOutput("add01_sticky", 32'(ovfSticky), 32'd1);
    checkOutput("add01_valid", 32'(outValid), 32'd1);

    // LOAD 0xFF then ADD 0x00 with carry-in: wraps to zero with carry out.
    applyStimulus("ldff", 1'b0, 1'b1, QL_OP_LOAD, 8'hFF, 1'b0);
    applyStimulus("addci", 1'b0, 1'b1, QL_OP_ADD, 8'h00, 1'b1);
    checkOutput("addci_q", 32'(q), 32'h00);
    checkOutput("addci_co", 32'(co), 32'd1);
    checkOutput("addci_ovf", 32'(ovf), 32'd0);

    // Subtract with borrow, then subtract 0x80.
    applyStimulus("ld05", 1'b0, 1'b1, QL_OP_LOAD, 8'h05, 1'b0);
    applyStimulus("sub07", 1'b0, 1'b1, QL_OP_SUB, 8'h07, 1'b1);
    checkOutput("sub07_q", 32'(q), 32'hFE);
    checkOutput("sub07_co", 32'(co), 32'd0);
    applyStimulus("sub80", 1'b0, 1'b1, QL_OP_SUB, 8'h80, 1'b0);
    checkOutput("sub80_q", 32'(q), 32'h7E);
    checkOutput("sub80_co", 32'(co), 32'd1);

    // HOLD then idle: state frozen, out_valid low.
    applyStimulus("ld7f_b", 1'b0, 1'b1, QL_OP_LOAD, 8'h7F, 1'b0);
    applyStimulus("ovf_b", 1'b0, 1'b1, QL_OP_ADD, 8'h7F, 1'b1);
    applyStimulus("hold", 1'b0, 1'b1, QL_OP_HOLD, 8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("idle", 1'b0, 1'b0, QL_OP_ADD, 8'h44, 1'b1);
      checkOutput("idle_valid", 32'(outValid), 32'd0);
    end

    // CLR beats a simultaneous ADD.
    applyStimulus("ld20", 1'b0, 1'b1, QL_OP_LOAD, 8'h20, 1'b0);
    applyStimulus("clr", 1'b1, 1'b1, QL_OP_ADD, 8'h10, 1'b0);
    checkOutput("clr_q", 32'(q), 32'h00);
    checkOutput("clr_sticky", 32'(ovfSticky), 32'd0);
    checkOutput("clr_valid", 32'(outValid), 32'd0);

    // Asynchronous reset in the middle of an ADD cycle.
    applyStimulus("ld5a", 1'b0, 1'b1, QL_OP_LOAD, 8'h5A, 1'b0);
    @(negedge clk);
    inValid = 1'b1; op = QL_OP_ADD; din = 8'h11; ciExt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    checkOutput("async_rst_q", 32'(q), 32'h00);
    @(negedge clk);
    inValid = 1'b0;
    rst_n = 1'b1;
    applyStimulus("post_rst", 1'b0, 1'b1, QL_OP_ADD, 8'h03, 1'b0);
    checkOutput("post_rst_q", 32'(q), 32'h03);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", ($urandom % 16) == 0, ($urandom % 4) != 0,
                    2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
